life_grid_core: RTL and testbench
=================================

LIFE_GRID_CORE -- requirements
Module: life_grid_core

Interface
REQ-001 SHALL have parameter W, default 8, grid columns (range 3..32).
REQ-002 SHALL have parameter H, default 8, grid rows (range 3..32).
REQ-003 SHALL have parameter WRAP, default 1: 1 = toroidal edges, 0 = cells beyond the border are dead.
REQ-004 SHALL define RW = max(1, clog2(H)) as the row-index width.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 ena  input  1  when low: FSM frozen, inputs ignored, outputs held.
REQ-008 load_en  input  1  write load_data into row load_row of the current grid.
REQ-009 load_row  input  RW  row index for loads.
REQ-010 load_data  input  W  row contents; bit c = column c, 1 = alive.
REQ-011 step  input  1  request one generation.
REQ-012 read_row  input  RW  row index for readout.
REQ-013 read_data  output  W  combinational view of current-grid row read_row.
REQ-014 busy  output  1  generation in progress.
REQ-015 done  output  1  one-cycle pulse on generation commit.
REQ-016 gen_count  output  16  committed generations since reset.
REQ-017 stable  output  1  last committed generation equalled its predecessor.
REQ-018 extinct  output  1  current grid contains no live cells.

Function
REQ-019 SHALL hold two W x H grids: cur (visible) and nxt (working).
REQ-020 SHALL implement FSM states IDLE, COMPUTE and COMMIT.
REQ-021 IDLE: load_en writes cur[load_row] <= load_data; step with load_en low moves to COMPUTE with row counter r = 0.
REQ-022 load_en and step high together in IDLE: load performed, step dropped.
REQ-023 load_en or step outside IDLE SHALL be ignored without side effects.
REQ-024 COMPUTE: each cycle compute nxt[r] from cur rows r-1, r, r+1; r increments; after r = H-1 move to COMMIT.
REQ-025 Cell rule B3/S23: dead cell with exactly 3 live neighbours is born; live cell with 2 or 3 survives; all others are dead.
REQ-026 Neighbour indices SHALL wrap modulo W/H when WRAP=1 and read as 0 when out of range when WRAP=0.
REQ-027 COMMIT: cur <= nxt, gen_count += 1 (wraps 0xFFFF -> 0), done = 1, stable <= (nxt == cur), then return to IDLE.
REQ-028 busy SHALL be 1 in COMPUTE and COMMIT, i.e. exactly H+1 cycles per accepted step; the next step is accepted in the cycle after done.
REQ-029 cur SHALL remain unchanged throughout COMPUTE; read_data shows the old generation until the COMMIT edge.
REQ-030 read_row >= H SHALL yield read_data = 0; load_row >= H SHALL make the load a no-op.
REQ-031 extinct SHALL be the combinational NOR of all cur bits.
REQ-032 A load in IDLE SHALL clear stable.

Reset
REQ-033 rst_n low SHALL immediately force: IDLE, r = 0, cur = 0, nxt = 0, gen_count = 0, busy = 0, done = 0, stable = 0; hence extinct = 1 and read_data = 0.
REQ-034 Reset asserted mid-COMPUTE SHALL abort the generation, with no partial commit after release.
REQ-035 The first step is accepted in the first enabled cycle after rst_n deasserts.

Verification
REQ-036 Blinker (8x8, WRAP=1): load row 3 = 0x1C, step -> after 9 cycles done; rows 2,3,4 = 0x08 each; second step restores row 3 = 0x1C; gen_count = 2.
REQ-037 Block still life: rows 3,4 = 0x18, step -> grid unchanged, stable = 1, gen_count = 1.
REQ-038 Glider on 8x8, WRAP=1: load rows 0..2 = 0x02, 0x04, 0x07; 32 steps -> grid identical to the initial load, gen_count = 32.
REQ-039 Edge rule, WRAP=0 vs WRAP=1: rows 0, 1, 7 = 0x01 each (vertical blinker crossing the wrap edge); step -> WRAP=1 gives row 0 = 0x83 with others 0; WRAP=0 gives extinct = 1.
REQ-040 Busy protection: step plus load_en during COMPUTE -> ignored; busy lasts exactly H+1 cycles; gen_count increments by 1 only.
REQ-041 Reset mid-operation: assert rst_n low at COMPUTE r = 4 -> busy = 0, gen_count = 0, extinct = 1 immediately; no done pulse after release.

Source files
------------

// File: rtl/life_grid_if.sv
// Purpose : bundles the control, load, readout and status signals of life_grid_core.
// Latency : no logic here; the timing is defined by the core.
// Backpressure: busy high means step and load requests are ignored.
// Ports   : master = driver side (testbench or host), slave = life_grid_core.
interface life_grid_if #(
  parameter int W = 8,
  parameter int H = 8
);
  localparam int RW = ($clog2(H) > 1) ? $clog2(H) : 1;

  logic          ena;
  logic          load_en;
  logic [RW-1:0] load_row;
  logic [W-1:0]  load_data;
  logic          step;
  logic [RW-1:0] read_row;
  logic [W-1:0]  read_data;
  logic          busy;
  logic          done;
  logic [15:0]   gen_count;
  logic          stable;
  logic          extinct;

  modport master (
    output ena, load_en, load_row, load_data, step, read_row,
    input  read_data, busy, done, gen_count, stable, extinct
  );

  modport slave (
    input  ena, load_en, load_row, load_data, step, read_row,
    output read_data, busy, done, gen_count, stable, extinct
  );
endinterface

// File: rtl/life_grid_core.sv
// Purpose : Conway's Life (B3/S23) engine holding a visible grid and a working grid.
// Latency : a step takes H+1 cycles (one row per cycle, then one commit cycle).
// Backpressure: while busy, step and load requests are dropped; ena low freezes everything.
// Ports   : clk, rst_n (async, active low) plus life_grid_if.slave bus carrying
//           ena/load_en/load_row/load_data/step/read_row in, and
//           read_data/busy/done/gen_count/stable/extinct out.
module life_grid_core #(
  parameter int W    = 8,
  parameter int H    = 8,
  parameter int WRAP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  life_grid_if.slave   bus
);
  localparam int RW = ($clog2(H) > 1) ? $clog2(H) : 1;
  localparam logic [RW:0]   H_V  = H[RW:0];
  localparam logic [RW-1:0] LAST = RW'(H - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t        state;
  logic [RW-1:0] r;
  logic [W-1:0]  cur [H];
  logic [W-1:0]  nxt [H];
  logic [15:0]   gen_count;
  logic          busy;
  logic          done;
  logic          stable;

  // Bit c receives the west neighbour of column c.
  function automatic logic [W-1:0] shift_w(input logic [W-1:0] x);
    return {x[W-2:0], (WRAP != 0) ? x[W-1] : 1'b0};
  endfunction

  // Bit c receives the east neighbour of column c.
  function automatic logic [W-1:0] shift_e(input logic [W-1:0] x);
    return {(WRAP != 0) ? x[0] : 1'b0, x[W-1:1]};
  endfunction

  function automatic logic [W-1:0] evolve(input logic [W-1:0] u,
                                          input logic [W-1:0] m,
                                          input logic [W-1:0] d);
    logic [W-1:0] res;
    logic [W-1:0] uw, ue, mw, me, dw, de;
    logic [3:0]   n;
    uw  = shift_w(u);
    ue  = shift_e(u);
    mw  = shift_w(m);
    me  = shift_e(m);
    dw  = shift_w(d);
    de  = shift_e(d);
    res = '0;
    for (int c = 0; c < W; c++) begin
      n = 4'(uw[c]) + 4'(u[c]) + 4'(ue[c]) + 4'(mw[c]) + 4'(me[c])
        + 4'(dw[c]) + 4'(d[c]) + 4'(de[c]);
      res[c] = (n == 4'd3) || (m[c] && (n == 4'd2));
    end
    return res;
  endfunction

  // Neighbour rows of the row being computed; rows beyond the border read
  // as dead unless the grid is toroidal.
  logic [RW-1:0] r_up, r_dn;
  logic [W-1:0]  row_u, row_d, new_row;

  always_comb begin
    r_up    = (r == '0)   ? LAST : r - 1'b1;
    r_dn    = (r == LAST) ? '0   : r + 1'b1;
    row_u   = ((r == '0)   && (WRAP == 0)) ? '0 : cur[r_up];
    row_d   = ((r == LAST) && (WRAP == 0)) ? '0 : cur[r_dn];
    new_row = evolve(row_u, cur[r], row_d);
  end

  logic any_live, same;

  always_comb begin
    any_live = 1'b0;
    same     = 1'b1;
    for (int i = 0; i < H; i++) begin
      any_live = any_live | (|cur[i]);
      if (nxt[i] != cur[i]) same = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '0;
      gen_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stable    <= 1'b0;
      for (int i = 0; i < H; i++) begin
        cur[i] <= '0;
        nxt[i] <= '0;
      end
    end else if (bus.ena) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A load takes priority; a simultaneous step is dropped.
          if (bus.load_en) begin
            if ({1'b0, bus.load_row} < H_V) begin
              cur[bus.load_row] <= bus.load_data;
              stable            <= 1'b0;
            end
          end else if (bus.step) begin
            state <= COMPUTE;
            r     <= '0;
            busy  <= 1'b1;
          end
        end
        COMPUTE: begin
          nxt[r] <= new_row;
          if (r == LAST) begin
            state <= COMMIT;
          end else begin
            r <= r + 1'b1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < H; i++) cur[i] <= nxt[i];
          gen_count <= gen_count + 16'd1;
          stable    <= same;
          done      <= 1'b1;
          busy      <= 1'b0;
          r         <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_data = ({1'b0, bus.read_row} < H_V) ? cur[bus.read_row] : '0;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.gen_count = gen_count;
  assign bus.stable    = stable;
  assign bus.extinct   = ~any_live;
endmodule

// File: tb/tb_life_grid_core.sv
// Purpose : directed checks of life_grid_core; a toroidal and a bounded instance share stimulus.
// Latency : expects H+1 busy cycles per step and done right after the commit edge.
// Backpressure: exercises requests issued while busy and with ena low.
module tb_life_grid_core;
  timeunit 1ns;
  timeprecision 100ps;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena, load_en, step;
  logic [2:0] load_row, read_row;
  logic [7:0] load_data;
  int         nvec = 0;
  int         nerr = 0;
  int         ncyc;

  always #5 clk = ~clk;

  life_grid_if #(.W(8), .H(8)) if_w ();
  life_grid_if #(.W(8), .H(8)) if_f ();

  assign if_w.ena = ena;             assign if_f.ena = ena;
  assign if_w.load_en = load_en;     assign if_f.load_en = load_en;
  assign if_w.load_row = load_row;   assign if_f.load_row = load_row;
  assign if_w.load_data = load_data; assign if_f.load_data = load_data;
  assign if_w.step = step;           assign if_f.step = step;
  assign if_w.read_row = read_row;   assign if_f.read_row = read_row;

  life_grid_core #(.W(8), .H(8), .WRAP(1)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));
  life_grid_core #(.W(8), .H(8), .WRAP(0)) u_flat (.clk(clk), .rst_n(rst_n), .bus(if_f.slave));

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input string tag, input logic [2:0] row, input logic [7:0] exp);
    read_row = row;
    #0.5;
    check_vec(tag, {24'd0, if_w.read_data}, {24'd0, exp});
  endtask

  task automatic load(input logic [2:0] row, input logic [7:0] data);
    load_en   = 1'b1;
    load_row  = row;
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one step, count busy cycles (bounded) and check the done pulse.
  task automatic do_step(input string tag, output int n);
    step = 1'b1;
    tick();
    step = 1'b0;
    n = 0;
    while (if_w.busy && n < 50) begin
      n++;
      tick();
    end
    check_vec({tag, " busy cycles"}, n, 9);
    check_vec({tag, " done"}, {31'd0, if_w.done}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end

  initial begin
    int dn;
    ena = 1'b1; load_en = 1'b0; step = 1'b0;
    load_row = '0; load_data = '0; read_row = '0;

    // Reset state, observed while rst_n is still low.
    #12;
    check_vec("rst busy",    {31'd0, if_w.busy}, 0);
    check_vec("rst done",    {31'd0, if_w.done}, 0);
    check_vec("rst gen",     {16'd0, if_w.gen_count}, 0);
    check_vec("rst stable",  {31'd0, if_w.stable}, 0);
    check_vec("rst extinct", {31'd0, if_w.extinct}, 1);
    check_row("rst row0", 3'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ena low freezes the FSM.
    ena = 1'b0; step = 1'b1;
    tick();
    check_vec("ena low busy", {31'd0, if_w.busy}, 0);
    step = 1'b0; ena = 1'b1;

    // Blinker, two generations.
    load(3'd3, 8'h1C);
    check_vec("blink extinct", {31'd0, if_w.extinct}, 0);
    do_step("blink1", ncyc);
    check_row("blink1 row2", 3'd2, 8'h08);
    check_row("blink1 row3", 3'd3, 8'h08);
    check_row("blink1 row4", 3'd4, 8'h08);
    check_row("blink1 row5", 3'd5, 8'h00);
    check_vec("blink1 gen", {16'd0, if_w.gen_count}, 1);
    check_vec("blink1 flat gen", {16'd0, if_f.gen_count}, 1);
    tick();
    check_vec("done one cycle", {31'd0, if_w.done}, 0);
    do_step("blink2", ncyc);
    check_row("blink2 row3", 3'd3, 8'h1C);
    check_row("blink2 row2", 3'd2, 8'h00);
    check_vec("blink2 gen", {16'd0, if_w.gen_count}, 2);
    check_vec("blink2 stable", {31'd0, if_w.stable}, 0);

    // Block still life.
    pulse_reset();
    load(3'd3, 8'h18);
    load(3'd4, 8'h18);
    do_step("block", ncyc);
    check_row("block row3", 3'd3, 8'h18);
    check_row("block row4", 3'd4, 8'h18);
    check_row("block row2", 3'd2, 8'h00);
    check_vec("block stable", {31'd0, if_w.stable}, 1);
    check_vec("block gen", {16'd0, if_w.gen_count}, 1);
    load(3'd0, 8'h00);
    check_vec("load clears stable", {31'd0, if_w.stable}, 0);

    // Glider: one diagonal cell per 4 generations, back home after 32.
    pulse_reset();
    load(3'd0, 8'h02);
    load(3'd1, 8'h04);
    load(3'd2, 8'h07);
    for (int s = 0; s < 4; s++) do_step("glider", ncyc);
    check_row("glider4 row0", 3'd0, 8'h00);
    check_row("glider4 row1", 3'd1, 8'h04);
    check_row("glider4 row2", 3'd2, 8'h08);
    check_row("glider4 row3", 3'd3, 8'h0E);
    for (int s = 4; s < 32; s++) do_step("glider", ncyc);
    check_row("glider32 row0", 3'd0, 8'h02);
    check_row("glider32 row1", 3'd1, 8'h04);
    check_row("glider32 row2", 3'd2, 8'h07);
    check_row("glider32 row3", 3'd3, 8'h00);
    check_row("glider32 row7", 3'd7, 8'h00);
    check_vec("glider gen", {16'd0, if_w.gen_count}, 32);

    // Vertical blinker straddling the row wrap edge.
    pulse_reset();
    load(3'd0, 8'h01);
    load(3'd1, 8'h01);
    load(3'd7, 8'h01);
    do_step("edge", ncyc);
    check_row("edge wrap row0", 3'd0, 8'h83);
    check_row("edge wrap row1", 3'd1, 8'h00);
    check_row("edge wrap row7", 3'd7, 8'h00);
    check_vec("edge wrap extinct", {31'd0, if_w.extinct}, 0);
    check_vec("edge flat extinct", {31'd0, if_f.extinct}, 1);

    // Step and load while busy are ignored.
    pulse_reset();
    load(3'd3, 8'h1C);
    step = 1'b1;
    tick();
    ncyc = 0;
    for (int k = 0; k < 3; k++) begin
      if (if_w.busy) ncyc++;
      load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF; step = 1'b1;
      tick();
    end
    load_en = 1'b0; step = 1'b0;
    while (if_w.busy && ncyc < 50) begin
      ncyc++;
      tick();
    end
    check_vec("busy prot cycles", ncyc, 9);
    check_vec("busy prot gen", {16'd0, if_w.gen_count}, 1);
    check_row("busy prot row0", 3'd0, 8'h00);
    check_row("busy prot row3", 3'd3, 8'h08);
    for (int k = 0; k < 12; k++) tick();
    check_vec("busy prot gen later", {16'd0, if_w.gen_count}, 1);

    // Reset in the middle of COMPUTE (row counter at 4).
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    check_vec("midrst busy", {31'd0, if_w.busy}, 0);
    check_vec("midrst gen", {16'd0, if_w.gen_count}, 0);
    check_vec("midrst extinct", {31'd0, if_w.extinct}, 1);
    check_row("midrst row3", 3'd3, 8'h00);
    tick();
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (if_w.done || if_f.done) dn++;
    end
    check_vec("midrst no done", dn, 0);
    check_vec("midrst gen after", {16'd0, if_w.gen_count}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
